lc3_fetch: RTL and testbench
============================

# lc3_fetch

Instruction-fetch stage of the LC-3 processor core. Holds the program counter (PC) and drives the instruction-memory read address. On each `fetch_start` request it advances the PC sequentially, or redirects it for taken branches and register-indirect jumps, using the opcode, offset, register value and condition codes supplied by the decode/execute logic. It never writes memory.

## Interface
Parameters:
- none (16-bit LC-3 datapath, fixed)

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `fetch_start`  in  1  advance request; the PC updates at the next rising edge while high
- `opCode_in`  in  4  opcode of the instruction just executed (IR[15:12])
- `offset_in`  in  9  PCoffset9 of that instruction (IR[8:0]), two's complement
- `reg_in`  in  16  base-register value for JMP/RET/JSRR targets
- `br_nzp`  in  3  n,z,p condition mask from the BR instruction (IR[11:9])
- `result_nzp`  in  3  current condition-code register {N,Z,P}
- `addr_out`  out  16  instruction-memory address (equals `pc`)
- `wea_out`  out  1  memory write enable; constant 0
- `pc`  out  16  current program counter

## Operation
- Opcode constants: BR = 4'b0000, JSR/JSRR = 4'b0100, JMP/RET = 4'b1100. All other opcodes are sequential.
- Next-PC selection, evaluated combinationally from the current `pc` and inputs:
  - BR and `(br_nzp & result_nzp) != 0`: `pc + 1 + sext16(offset_in)`
  - BR not taken, including `br_nzp = 000` (NOP): `pc + 1`
  - JMP/RET (1100): `reg_in`
  - 0100: `reg_in` (register form only; the 11-bit JSR offset form is not supported)
  - any other opcode: `pc + 1`
- Arithmetic is 16-bit modulo 2^16. 0xFFFF + 1 wraps to 0x0000, and negative offsets wrap below 0x0000.
- `offset_in` is sign-extended from bit 8.
- Condition-code inputs are used raw as a bitwise AND; the block does not check them for validity.
- `addr_out` is driven continuously from the PC register. `wea_out` is tied to 0.
- With `fetch_start` low, the PC holds its value regardless of the other inputs.

## Timing
- Reset (asynchronous, `rst_n` = 0): `pc` = 0x0000, `addr_out` = 0x0000, `wea_out` = 0, effective immediately without waiting for a clock edge. Asserting reset mid-operation discards any pending update.
- After release of `rst_n`, the PC stays at 0x0000 until the first rising edge that samples `fetch_start` = 1.
- Latency: one cycle. Inputs sampled at edge N with `fetch_start` = 1 produce the new `pc`/`addr_out` immediately after edge N.
- If `fetch_start` is held high, the PC advances on every edge. There is no handshake or acknowledge.
- Inputs need to be stable only around the sampling edge at which `fetch_start` = 1.

## Structure
- Shared package `lc3_pkg`: opcode localparams (`OP_BR`, `OP_JSR`, `OP_JMP`), the `sext9to16` function, and the 16-bit word width.
- One sub-module, `lc3_pc_next`: purely combinational next-PC calculator (inputs: pc, opcode, offset, reg_in, br_nzp, result_nzp; output: next_pc).
- Top level: the PC register with asynchronous reset and the enable from `fetch_start`; output assignments.

## Test plan
- Reset, idle: hold `rst_n` = 0 for 5 cycles with `fetch_start` = 0 and `opCode_in` = 0000, then release. Required: `addr_out` = 0, `wea_out` = 0, `pc` = 0, and the outputs remain 0 while `fetch_start` stays 0.
- Sequential: opcode 0001 with `fetch_start` high for 3 edges from reset. Required: `pc` = 1, 2, 3, with `addr_out` tracking `pc`.
- Branch taken and not taken, from pc = 0x0010:
  - `br_nzp` = 010, `result_nzp` = 010, offset = 0x005 -> `pc` = 0x0016
  - same with `result_nzp` = 100 -> `pc` = 0x0011
  - offset = 0x1FF (−1), taken -> `pc` = 0x0010
- JMP/JSRR: opcode 1100 with `reg_in` = 0x3000 -> `pc` = 0x3000. Opcode 0100 with `reg_in` = 0x1234 -> `pc` = 0x1234.
- Wrap-around: pc = 0xFFFF, sequential step -> `pc` = 0x0000. From pc = 0x0000, taken BR with offset 0x100 (−256) -> `pc` = 0xFF01.
- Reset mid-run: assert `rst_n` low between clock edges while `fetch_start` = 1 and pc = 0x0042. Required: `pc`/`addr_out` = 0 immediately, with `wea_out` = 0 throughout all scenarios.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: word width, control-flow opcodes, sign extension.
package lc3_pkg;

  localparam int WORD_W = 16;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b1100;

  function automatic logic [WORD_W-1:0] sext9to16(input logic [8:0] v);
    return {{(WORD_W-9){v[8]}}, v};
  endfunction

endpackage

// File: rtl/lc3_fetch_if.sv
// Fetch-stage bus: decode/execute feedback in, instruction-memory address out.
interface lc3_fetch_if;
  import lc3_pkg::*;

  logic              fetch_start;
  logic [3:0]        opCode_in;
  logic [8:0]        offset_in;
  logic [WORD_W-1:0] reg_in;
  logic [2:0]        br_nzp;
  logic [2:0]        result_nzp;
  logic [WORD_W-1:0] addr_out;
  logic              wea_out;
  logic [WORD_W-1:0] pc;

  // Driven by the decode/execute side.
  modport master (
    output fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
    input  addr_out, wea_out, pc
  );

  // The fetch stage itself.
  modport slave (
    input  fetch_start, opCode_in, offset_in, reg_in, br_nzp, result_nzp,
    output addr_out, wea_out, pc
  );
endinterface

// File: rtl/lc3_pc_next.sv
// Combinational next-PC calculator: sequential, conditional branch, or
// register-indirect jump (JMP/RET and JSRR share the register target).
module lc3_pc_next
  import lc3_pkg::*;
(
  input  logic [WORD_W-1:0] pc,
  input  logic [3:0]        opcode,
  input  logic [8:0]        offset,
  input  logic [WORD_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
  output logic [WORD_W-1:0] next_pc
);

  logic [WORD_W-1:0] pc_inc;
  logic              br_taken;

  assign pc_inc   = pc + 16'd1;
  assign br_taken = |(br_nzp & result_nzp);

  // Select the target; all sums wrap modulo 2^16.
  always_comb begin
    next_pc = pc_inc;
    case (opcode)
      OP_BR:   next_pc = br_taken ? (pc_inc + sext9to16(offset)) : pc_inc;
      OP_JMP:  next_pc = reg_in;
      OP_JSR:  next_pc = reg_in;
      default: next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/lc3_fetch.sv
// LC-3 instruction fetch: PC register, advanced once per edge while
// fetch_start is high. Memory is read-only from this stage.
module lc3_fetch
  import lc3_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  lc3_fetch_if.slave    bus
);

  logic [WORD_W-1:0] pc_q;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] next_pc;

  lc3_pc_next u_pc_next (
    .pc         (pc_q),
    .opcode     (bus.opCode_in),
    .offset     (bus.offset_in),
    .reg_in     (bus.reg_in),
    .br_nzp     (bus.br_nzp),
    .result_nzp (bus.result_nzp),
    .next_pc    (next_pc)
  );

  // Hold the PC unless an advance is requested.
  always_comb begin
    pc_d = pc_q;
    if (bus.fetch_start) pc_d = next_pc;
  end

  // PC register; reset takes effect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign bus.pc       = pc_q;
  assign bus.addr_out = pc_q;
  assign bus.wea_out  = 1'b0;

endmodule

// File: tb/tb_lc3_fetch.sv
// Directed bench for lc3_fetch with hand-computed PC values.
module tb_lc3_fetch;
  import lc3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  lc3_fetch_if bus ();

  lc3_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
  endtask

  task automatic chk_pc(input string tag, input logic [15:0] exp);
    chk({tag, ".pc"}, bus.pc, exp);
    chk({tag, ".addr"}, bus.addr_out, exp);
    chk({tag, ".wea"}, {15'd0, bus.wea_out}, 16'h0000);
  endtask

  task automatic drive(input logic fs, input logic [3:0] op, input logic [8:0] off,
                       input logic [15:0] r, input logic [2:0] bn, input logic [2:0] rn);
    bus.fetch_start = fs;
    bus.opCode_in   = op;
    bus.offset_in   = off;
    bus.reg_in      = r;
    bus.br_nzp      = bn;
    bus.result_nzp  = rn;
  endtask

  // One clock edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 4'b0000, 9'h000, 16'h0000, 3'b000, 3'b000);
    #2;
    chk_pc("reset_async", 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    chk_pc("reset_held", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_pc("idle_after_reset", 16'h0000);

    // Sequential steps.
    drive(1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    tick(); chk_pc("seq1", 16'h0001);
    tick(); chk_pc("seq2", 16'h0002);
    tick(); chk_pc("seq3", 16'h0003);

    // Hold with fetch_start low despite a jump opcode.
    drive(1'b0, OP_JMP, 9'h000, 16'hBEEF, 3'b111, 3'b111);
    tick(); tick(); chk_pc("hold", 16'h0003);

    // Branches from 0x0010.
    drive(1'b1, OP_JMP, 9'h000, 16'h0010, 3'b000, 3'b000);
    tick(); chk_pc("jmp_0010", 16'h0010);
    drive(1'b1, OP_BR, 9'h005, 16'h0000, 3'b010, 3'b010);
    tick(); chk_pc("br_taken", 16'h0016);

    drive(1'b1, OP_JMP, 9'h000, 16'h0010, 3'b000, 3'b000);
    tick();
    drive(1'b1, OP_BR, 9'h005, 16'h0000, 3'b010, 3'b100);
    tick(); chk_pc("br_not_taken", 16'h0011);

    drive(1'b1, OP_JMP, 9'h000, 16'h0010, 3'b000, 3'b000);
    tick();
    drive(1'b1, OP_BR, 9'h1FF, 16'h0000, 3'b001, 3'b001);
    tick(); chk_pc("br_minus1", 16'h0010);

    drive(1'b1, OP_BR, 9'h005, 16'h0000, 3'b000, 3'b111);
    tick(); chk_pc("br_nop", 16'h0011);

    // Register-indirect targets.
    drive(1'b1, OP_JMP, 9'h000, 16'h3000, 3'b000, 3'b000);
    tick(); chk_pc("jmp", 16'h3000);
    drive(1'b1, OP_JSR, 9'h0AA, 16'h1234, 3'b000, 3'b000);
    tick(); chk_pc("jsrr", 16'h1234);

    // Wrap-around.
    drive(1'b1, OP_JMP, 9'h000, 16'hFFFF, 3'b000, 3'b000);
    tick(); chk_pc("jmp_ffff", 16'hFFFF);
    drive(1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    tick(); chk_pc("wrap_inc", 16'h0000);
    drive(1'b1, OP_BR, 9'h100, 16'h0000, 3'b100, 3'b100);
    tick(); chk_pc("wrap_neg", 16'hFF01);

    // Reset between edges while advancing.
    drive(1'b1, OP_JMP, 9'h000, 16'h0042, 3'b000, 3'b000);
    tick(); chk_pc("jmp_0042", 16'h0042);
    drive(1'b1, 4'b0001, 9'h000, 16'h0000, 3'b000, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_pc("reset_mid", 16'h0000);
    tick(); chk_pc("reset_mid_held", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk_pc("post_reset_seq", 16'h0001);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
